board_input_conditioner: RTL and testbench

BOARD_INPUT_CONDITIONER -- requirements
Module: board_input_conditioner

---
 rtl/board_io_pkg.sv | 27 ++
 rtl/board_key_channel.sv | 170 +++++++++++++++++
 rtl/board_input_conditioner.sv | 91 +++++++++
 tb/tb_board_input_conditioner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : board_io_pkg
//  Description : Shared types and helpers for the board input conditioner.
//                - key_state_e : per-key press state (RELEASED/HELD/LONG)
//                - cnt_width() : width of a counter that must reach a value
//                                without wrapping
//  Revision    : 1.0  initial release
// ============================================================================
package board_io_pkg;

  typedef enum logic [1:0] {
    KEY_RELEASED = 2'd0,
    KEY_HELD     = 2'd1,
    KEY_LONG     = 2'd2
  } key_state_e;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    int r;
    r = $clog2(max_val + 1);
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/board_key_channel.sv
`default_nettype none
// ============================================================================
//  Module      : board_key_channel
//  Description : One key channel: 2-flop synchroniser, optional inversion,
//                debouncer, RELEASED/HELD/LONG state machine and pulses.
//                Build option BOARD_INPUT_REPEAT_EN adds auto-repeat pulses
//                while the key sits in LONG; otherwise key_repeat_o is 0.
//  Ports       : clk, reset (async, active-high)
//                key_i          raw asynchronous key
//                key_level_o    debounced active-high level
//                key_press_o    1-cycle pulse on debounced rise
//                key_release_o  1-cycle pulse on debounced fall
//                key_long_o     1-cycle pulse on HELD->LONG
//                key_repeat_o   1-cycle auto-repeat pulse
//  Revision    : 1.0  initial release
// ============================================================================
module board_key_channel
  import board_io_pkg::*;
#(
  parameter int active_low      = 1,
  parameter int debounce_cycles = 50000,
  parameter int long_cycles     = 25000000,
  parameter int repeat_cycles   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_i,
  output logic key_level_o,
  output logic key_press_o,
  output logic key_release_o,
  output logic key_long_o,
  output logic key_repeat_o
);

  localparam logic INV  = (active_low != 0);
  localparam int   DB_W = cnt_width(debounce_cycles);
  localparam int   HL_W = cnt_width(long_cycles);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(debounce_cycles - 1);
  localparam logic [HL_W-1:0] HL_LAST = HL_W'(long_cycles - 1);

  logic            meta_q, sync_q;
  logic            level_q, level_d;
  logic [DB_W-1:0] db_q, db_d;
  logic [HL_W-1:0] hold_q, hold_d;
  key_state_e      state_q, state_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;
  logic            key_act;

  assign key_act = INV ? ~sync_q : sync_q;

  always_comb begin
    level_d   = level_q;
    db_d      = db_q;
    hold_d    = hold_q;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    if (key_act == level_q) begin
      db_d = '0;
    end else if (db_q == DB_LAST) begin
      db_d      = '0;
      level_d   = ~level_q;
      press_d   = ~level_q;
      release_d = level_q;
    end else begin
      db_d = db_q + DB_W'(1);
    end

    case (state_q)
      KEY_RELEASED: begin
        if (press_d) begin
          state_d = KEY_HELD;
          hold_d  = '0;
        end
      end
      KEY_HELD: begin
        // A fall in the threshold cycle takes priority over the long pulse.
        if (release_d) begin
          state_d = KEY_RELEASED;
        end else if (hold_q == HL_LAST) begin
          state_d = KEY_LONG;
          hold_d  = hold_q + HL_W'(1);
          long_d  = 1'b1;
        end else begin
          hold_d = hold_q + HL_W'(1);
        end
      end
      KEY_LONG: begin
        if (release_d) state_d = KEY_RELEASED;
      end
      default: state_d = KEY_RELEASED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // Synchroniser resets to the idle level so no press follows reset.
      meta_q    <= INV;
      sync_q    <= INV;
      level_q   <= 1'b0;
      db_q      <= '0;
      hold_q    <= '0;
      state_q   <= KEY_RELEASED;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      meta_q    <= key_i;
      sync_q    <= meta_q;
      level_q   <= level_d;
      db_q      <= db_d;
      hold_q    <= hold_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign key_level_o   = level_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;
  assign key_long_o    = long_q;

`ifdef BOARD_INPUT_REPEAT_EN
  localparam int RP_W = cnt_width(repeat_cycles);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(repeat_cycles - 1);

  logic [RP_W-1:0] rep_q, rep_d;
  logic            rep_pulse_q, rep_pulse_d;

  // Repeat phase restarts on LONG entry; only runs while staying in LONG.
  always_comb begin
    rep_d       = rep_q;
    rep_pulse_d = 1'b0;
    if (state_q == KEY_HELD && state_d == KEY_LONG) begin
      rep_d = '0;
    end else if (state_q == KEY_LONG && state_d == KEY_LONG) begin
      if (rep_q == RP_LAST) begin
        rep_d       = '0;
        rep_pulse_d = 1'b1;
      end else begin
        rep_d = rep_q + RP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_q       <= '0;
      rep_pulse_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_pulse_q <= rep_pulse_d;
    end
  end

  assign key_repeat_o = rep_pulse_q;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^repeat_cycles;
  assign key_repeat_o      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/board_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : board_input_conditioner
//  Description : w debounced key channels with press/release/long/repeat
//                pulses, plus PLL-lock synchroniser and reset stretcher.
//                Build option BOARD_INPUT_REPEAT_EN enables key_repeat.
//  Ports       : clk, reset (async, active-high)
//                key_in[w]      raw asynchronous keys
//                pll_locked     raw asynchronous PLL lock
//                key_level[w]   debounced active-high levels
//                key_press[w], key_release[w], key_long[w], key_repeat[w]
//                               one-cycle event pulses
//                reset_out      active-high reset for user logic
//  Revision    : 1.0  initial release
// ============================================================================
module board_input_conditioner
  import board_io_pkg::*;
#(
  parameter int w               = 4,
  parameter int active_low      = 1,
  parameter int debounce_cycles = 50000,
  parameter int long_cycles     = 25000000,
  parameter int repeat_cycles   = 5000000,
  parameter int rst_stretch     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [w-1:0] key_in,
  input  logic         pll_locked,
  output logic [w-1:0] key_level,
  output logic [w-1:0] key_press,
  output logic [w-1:0] key_release,
  output logic [w-1:0] key_long,
  output logic [w-1:0] key_repeat,
  output logic         reset_out
);

  for (genvar i = 0; i < w; i++) begin : g_chan
    board_key_channel #(
      .active_low      (active_low),
      .debounce_cycles (debounce_cycles),
      .long_cycles     (long_cycles),
      .repeat_cycles   (repeat_cycles)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .key_i         (key_in[i]),
      .key_level_o   (key_level[i]),
      .key_press_o   (key_press[i]),
      .key_release_o (key_release[i]),
      .key_long_o    (key_long[i]),
      .key_repeat_o  (key_repeat[i])
    );
  end

  localparam int ST_W = cnt_width(rst_stretch);
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(rst_stretch);

  logic            lock_meta_q, lock_sync_q;
  logic [ST_W-1:0] stretch_q, stretch_d;
  logic            reset_out_q, reset_out_d;

  // Stretch counter saturates at rst_stretch; any lock loss restarts it.
  always_comb begin
    stretch_d = stretch_q;
    if (!lock_sync_q) begin
      stretch_d = '0;
    end else if (stretch_q != ST_MAX) begin
      stretch_d = stretch_q + ST_W'(1);
    end
    reset_out_d = !lock_sync_q || (stretch_d != ST_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      stretch_q   <= '0;
      reset_out_q <= 1'b1;
    end else begin
      lock_meta_q <= pll_locked;
      lock_sync_q <= lock_meta_q;
      stretch_q   <= stretch_d;
      reset_out_q <= reset_out_d;
    end
  end

  assign reset_out = reset_out_q;

endmodule
`default_nettype wire

// File: tb/tb_board_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_input_conditioner
//  Description : Self-checking bench for board_input_conditioner
//                (w=4, debounce=4, long=20, repeat=8, stretch=4, active_low).
//                Expected pulse events are queued at stimulus time and
//                compared against the pulses the DUT emits.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_board_input_conditioner;

  localparam int W   = 4;
  localparam int DB  = 4;
  localparam int LNG = 20;
  localparam int REP = 8;
  localparam int STR = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] key_in;
  logic         pll_locked;
  logic [W-1:0] key_level, key_press, key_release, key_long, key_repeat;
  logic         reset_out;

  board_input_conditioner #(
    .w               (W),
    .active_low      (1),
    .debounce_cycles (DB),
    .long_cycles     (LNG),
    .repeat_cycles   (REP),
    .rst_stretch     (STR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_in      (key_in),
    .pll_locked  (pll_locked),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .key_repeat  (key_repeat),
    .reset_out   (reset_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [15:0] bits;   // {press, release, long, repeat}
  } evt_t;

  evt_t sb_q[$];

  task automatic push(input int c, input logic [15:0] b);
    evt_t e;
    e.cyc  = c;
    e.bits = b;
    sb_q.push_back(e);
  endtask

  logic [15:0] obs;
  assign obs = {key_press, key_release, key_long, key_repeat};

  always @(negedge clk) begin : mon
    evt_t e;
    if (!reset && (obs != 16'd0)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {16'd0, obs}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("evt_cycle", cyc, e.cyc);
        check("evt_bits", {16'd0, obs}, {16'd0, e.bits});
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Hold key ch low for hold_len cycles starting at the current negedge.
  task automatic press_release(input int ch, input int hold_len);
    int n, p, f, t_rel, t_chk;
    logic [15:0] pb, rb, lb, qb;
    pb = 16'h1000 << ch;
    rb = 16'h0100 << ch;
    lb = 16'h0010 << ch;
    qb = 16'h0001 << ch;
    n  = cyc;
    p  = n + DB + 2;
    f  = n + hold_len + DB + 2;
    key_in[ch] = 1'b0;
    if (hold_len >= DB) begin
      push(p, pb);
      if (f > p + LNG) begin
        push(p + LNG, lb);
`ifdef BOARD_INPUT_REPEAT_EN
        for (int t = p + LNG + REP; t < f; t += REP) push(t, qb);
`endif
      end
      push(f, rb);
    end
    t_rel = n + hold_len;
    t_chk = n + DB + 2;
    if (t_chk <= t_rel) begin
      wait_to(t_chk);
      check("level_held", {28'd0, key_level}, (hold_len >= DB) ? (32'd1 << ch) : 32'd0);
      wait_to(t_rel);
      key_in[ch] = 1'b1;
    end else begin
      wait_to(t_rel);
      key_in[ch] = 1'b1;
      wait_to(t_chk);
      check("level_held", {28'd0, key_level}, (hold_len >= DB) ? (32'd1 << ch) : 32'd0);
    end
    wait_to(f + 1);
    check("level_idle", {28'd0, key_level}, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin : main
    int n, m, r;
    reset      = 1'b1;
    pll_locked = 1'b0;
    key_in     = 4'hF;
    repeat (3) @(negedge clk);

    check("rst_level",   {28'd0, key_level}, 32'd0);
    check("rst_pulses",  {16'd0, obs}, 32'd0);
    check("rst_out",     {31'd0, reset_out}, 32'd1);

    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("ro_unlocked", {31'd0, reset_out}, 32'd1);

    // Lock rise: release after 2 sync + STR stretch edges.
    n = cyc;
    pll_locked = 1'b1;
    wait_to(n + 2 + STR - 1);
    check("ro_before_rel", {31'd0, reset_out}, 32'd1);
    wait_to(n + 2 + STR);
    check("ro_released", {31'd0, reset_out}, 32'd0);
    repeat (3) @(negedge clk);

    // One-cycle lock drop: reassert, then a full new stretch.
    m = cyc;
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    wait_to(m + 2);
    check("ro_drop_early", {31'd0, reset_out}, 32'd0);
    wait_to(m + 3);
    check("ro_drop_reassert", {31'd0, reset_out}, 32'd1);
    wait_to(m + 6);
    check("ro_restretch_hold", {31'd0, reset_out}, 32'd1);
    wait_to(m + 7);
    check("ro_restretch_rel", {31'd0, reset_out}, 32'd0);
    repeat (3) @(negedge clk);

    press_release(0, 10);   // plain press/release
    press_release(1, 3);    // glitch below debounce: silent
    press_release(1, 4);    // shortest accepted press
    press_release(2, 40);   // long press with repeats (when built in)
    press_release(3, 20);   // fall coincides with long threshold
    press_release(3, 21);   // fall one cycle after long

    // Reset in mid-hold of keys 0 and 3.
    n = cyc;
    key_in = 4'b0110;
    push(n + DB + 2, 16'h9000);
    wait_to(n + DB + 2);
    check("dual_level", {28'd0, key_level}, 32'h9);
    wait_to(n + DB + 4);
    reset = 1'b1;
    #1;
    check("mid_rst_level",  {28'd0, key_level}, 32'd0);
    check("mid_rst_pulses", {16'd0, obs}, 32'd0);
    check("mid_rst_out",    {31'd0, reset_out}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    r = cyc;
    push(r + DB + 2, 16'h9000);
    wait_to(r + DB + 1);
    check("re_press_pending", {28'd0, key_level}, 32'd0);
    check("post_rst_ro_hold", {31'd0, reset_out}, 32'd1);
    wait_to(r + DB + 2);
    check("re_press_level", {28'd0, key_level}, 32'h9);
    check("post_rst_ro_rel", {31'd0, reset_out}, 32'd0);
    wait_to(r + 8);
    key_in = 4'hF;
    push(r + 8 + DB + 2, 16'h0900);
    wait_to(r + 8 + DB + 3);
    check("dual_idle", {28'd0, key_level}, 32'd0);

    repeat (10) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
